// File: rtl/crash_watchdog_pkg.sv
// crash_watchdog_pkg: fault codes, report header and FSM encodings shared by the watchdog
package crash_watchdog_pkg;
  localparam logic [2:0] FAULT_NONE = 3'd0;
  localparam logic [2:0] FAULT_NAND_BUSY = 3'd1;
  localparam logic [2:0] FAULT_UART_INC = 3'd2;
  localparam logic [2:0] FAULT_FLASH_LEN = 3'd3;
  localparam logic [4:0] REPORT_HDR = 5'b10100;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, BUSY, TIMEOUT} nand_state_t;
  typedef enum logic {R_IDLE, R_REQ} rep_state_t;
  function automatic logic [7:0] report_byte(logic [2:0] code);
    return {REPORT_HDR, code};
  endfunction
endpackage

// File: rtl/crash_watchdog_timeout_counter.sv
// timeout_counter: clearable, enabled up-counter that saturates at a limit and flags it
module timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign hit_o = cnt_q >= limit_i;
  // clear wins over enable; counting stops at the limit so it never wraps
  always_comb cnt_d = clr_i ? '0 : (en_i && !hit_o) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/crash_watchdog.sv
// crash_watchdog: NAND busy / UART frame / flash length fault monitor with byte reporting
module crash_watchdog
  import crash_watchdog_pkg::*;
#(
  parameter logic [23:0] BUSY_TIMEOUT = 24'd5_000_000,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd50_000,
  parameter logic [4:0]  TWB_MAX = 5'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nand_op_start,
  input  logic       nand_rb_n,
  input  logic       uart_rx_valid,
  input  logic       flash_len_err,
  input  logic       fault_clear,
  input  logic       report_ack,
  output logic [2:0] fault_code,
  output logic       report_req,
  output logic [7:0] report_data
);
  logic rb_s1_q, rb_s2_q;
  nand_state_t ns_q, ns_d;
  rep_state_t rs_q, rs_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] fc_q, fc_d, ev;
  logic twb_hit, busy_hit, gap_hit, uart_to;
  timeout_counter #(.W(5)) u_twb (
    .clk(clk), .rst(rst), .en_i(ns_q == WAIT_BUSY), .clr_i(ns_q != WAIT_BUSY),
    .limit_i(TWB_MAX), .hit_o(twb_hit)
  );
  timeout_counter #(.W(24)) u_busy (
    .clk(clk), .rst(rst), .en_i(ns_q == BUSY), .clr_i(ns_q == IDLE),
    .limit_i(BUSY_TIMEOUT), .hit_o(busy_hit)
  );
  timeout_counter #(.W(16)) u_gap (
    .clk(clk), .rst(rst), .en_i(idx_q != 2'd0 && !uart_rx_valid),
    .clr_i(uart_rx_valid || idx_q == 2'd0 || gap_hit),
    .limit_i(BYTE_TIMEOUT), .hit_o(gap_hit)
  );
  assign uart_to = gap_hit && !uart_rx_valid;
  assign ev = (ns_q == TIMEOUT) ? FAULT_NAND_BUSY : uart_to ? FAULT_UART_INC :
              flash_len_err ? FAULT_FLASH_LEN : FAULT_NONE;
  // NAND operation tracking on the synchronized ready/busy level
  always_comb begin
    ns_d = ns_q;
    unique case (ns_q)
      IDLE:      ns_d = nand_op_start ? WAIT_BUSY : IDLE;
      WAIT_BUSY: ns_d = !rb_s2_q ? BUSY : twb_hit ? IDLE : WAIT_BUSY;
      BUSY:      ns_d = rb_s2_q ? IDLE : busy_hit ? TIMEOUT : BUSY;
      TIMEOUT:   ns_d = IDLE;
    endcase
  end
  // frame index, sticky prioritised fault code and report handshake
  always_comb begin
    idx_d = uart_rx_valid ? idx_q + 2'd1 : gap_hit ? 2'd0 : idx_q;
    fc_d = fault_clear ? ev :
           (ev != FAULT_NONE && (fc_q == FAULT_NONE || ev < fc_q)) ? ev : fc_q;
    rs_d = (fc_d != fc_q && fc_d != FAULT_NONE) ? R_REQ :
           (rs_q == R_REQ && report_ack) ? R_IDLE : rs_q;
  end
  // state registers; synchronizer flops preset to the idle (ready) level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rb_s1_q <= 1'b1;
      rb_s2_q <= 1'b1;
      ns_q <= IDLE;
      rs_q <= R_IDLE;
      idx_q <= 2'd0;
      fc_q <= FAULT_NONE;
    end else begin
      rb_s1_q <= nand_rb_n;
      rb_s2_q <= rb_s1_q;
      ns_q <= ns_d;
      rs_q <= rs_d;
      idx_q <= idx_d;
      fc_q <= fc_d;
    end
  assign fault_code = fc_q;
  assign report_req = rs_q == R_REQ;
  assign report_data = report_byte(fc_q);
endmodule

// File: tb/tb_crash_watchdog.sv
// tb_crash_watchdog: randomized scoreboard bench for the crash watchdog
module tb_crash_watchdog;
  logic clk = 0, rst = 1;
  logic nand_op_start = 0, nand_rb_n = 1, uart_rx_valid = 0, flash_len_err = 0;
  logic fault_clear = 0, report_ack = 0;
  logic [2:0] fault_code;
  logic report_req;
  logic [7:0] report_data;
  int n_chk = 0, n_fail = 0;
  logic [2:0] exp_fc = 0;
  logic [7:0] exp_q[$];
  bit ack_hold = 0;

  crash_watchdog #(.BUSY_TIMEOUT(24'd100), .BYTE_TIMEOUT(16'd20), .TWB_MAX(5'd16)) dut (
    .clk(clk), .rst(rst), .nand_op_start(nand_op_start), .nand_rb_n(nand_rb_n),
    .uart_rx_valid(uart_rx_valid), .flash_len_err(flash_len_err), .fault_clear(fault_clear),
    .report_ack(report_ack), .fault_code(fault_code), .report_req(report_req),
    .report_data(report_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void expect_report();
    logic [7:0] b = {5'b10100, exp_fc};
    if (ack_hold && exp_q.size() > 0) exp_q[exp_q.size() - 1] = b;
    else exp_q.push_back(b);
  endfunction

  function automatic void model_event(logic [2:0] ev);
    if (ev != 0 && (exp_fc == 0 || ev < exp_fc)) begin
      exp_fc = ev;
      expect_report();
    end
  endfunction

  function automatic void model_clear(logic [2:0] ev);
    logic [2:0] old = exp_fc;
    exp_fc = ev;
    if (ev != 0 && ev != old) expect_report();
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_flash();
    flash_len_err = 1;
    tick(1);
    flash_len_err = 0;
  endtask

  task automatic pulse_clear();
    fault_clear = 1;
    tick(1);
    fault_clear = 0;
  endtask

  task automatic nand_op(int len);
    nand_op_start = 1;
    if (len > 0) nand_rb_n = 0;
    tick(1);
    nand_op_start = 0;
    if (len > 1) tick(len - 1);
    nand_rb_n = 1;
  endtask

  task automatic nand_timeout(output int n);
    nand_op_start = 1;
    nand_rb_n = 0;
    tick(1);
    nand_op_start = 0;
    n = 1;
    while (fault_code != 3'd1 && n < 300) begin
      tick(1);
      n++;
    end
    if (n < 200) tick(200 - n);
    nand_rb_n = 1;
  endtask

  task automatic uart_bytes(int cnt, int max_gap);
    for (int i = 0; i < cnt; i++) begin
      uart_rx_valid = 1;
      tick(1);
      uart_rx_valid = 0;
      if (max_gap > 0) tick($urandom_range(0, max_gap));
    end
  endtask

  // transmitter side: acknowledge each request and compare against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (report_req && !ack_hold && !rst) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("report_data", report_data, exp_q.size() > 0 ? exp_q.pop_front() : 8'h00);
        report_ack = 1;
        @(negedge clk);
        report_ack = 0;
      end
    end
  end

  initial begin
    int n;
    tick(3);
    rst = 0;
    tick(1);
    check("reset_code", fault_code, 0);
    check("reset_req", report_req, 0);
    check("reset_data", report_data, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      nand_op($urandom_range(5, 80));
      tick(20);
      check("short_busy", fault_code, exp_fc);
    end
    model_event(1);
    nand_timeout(n);
    check("busy_timeout_window", (n >= 95 && n <= 112), 1);
    tick(10);
    check("busy_timeout_code", fault_code, exp_fc);
    model_clear(0);
    pulse_clear();
    tick(5);
    check("clear_alone", fault_code, exp_fc);
    model_event(2);
    uart_bytes(2, 0);
    tick(15);
    check("uart_before_gap", fault_code, 0);
    tick(10);
    check("uart_gap_fault", fault_code, exp_fc);
    model_clear(0);
    pulse_clear();
    uart_bytes(8, 0);
    tick(30);
    check("uart_back_to_back", fault_code, exp_fc);
    uart_bytes(4, 15);
    tick(30);
    check("uart_random_frame", fault_code, exp_fc);
    model_event(3);
    pulse_flash();
    tick(10);
    check("flash_len", fault_code, exp_fc);
    model_event(1);
    nand_timeout(n);
    tick(10);
    check("flash_then_busy", fault_code, exp_fc);
    model_event(3);
    pulse_flash();
    tick(10);
    check("busy_then_flash", fault_code, exp_fc);
    model_clear(3);
    fault_clear = 1;
    flash_len_err = 1;
    tick(1);
    fault_clear = 0;
    flash_len_err = 0;
    tick(10);
    check("clear_with_flash", fault_code, exp_fc);
    model_clear(0);
    pulse_clear();
    tick(10);
    check("clear_after_flash", fault_code, exp_fc);
    ack_hold = 1;
    model_event(3);
    pulse_flash();
    tick(3);
    check("held_req", report_req, 1);
    check("held_data_first", report_data, 8'hA3);
    model_event(1);
    nand_timeout(n);
    tick(2);
    check("held_req_kept", report_req, 1);
    check("held_data_latest", report_data, 8'hA1);
    ack_hold = 0;
    tick(10);
    check("held_code", fault_code, exp_fc);
    model_clear(0);
    pulse_clear();
    tick(5);
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: begin model_event(3); pulse_flash(); end
        1: begin model_clear(0); pulse_clear(); end
        2: nand_op($urandom_range(0, 60));
        default: uart_bytes(4, 15);
      endcase
      tick(25);
      check("random_mix", fault_code, exp_fc);
    end
    model_clear(0);
    pulse_clear();
    tick(10);
    ack_hold = 1;
    model_event(3);
    pulse_flash();
    nand_op_start = 1;
    nand_rb_n = 0;
    tick(1);
    nand_op_start = 0;
    tick(60);
    rst = 1;
    #1;
    check("rst_mid_code", fault_code, 0);
    check("rst_mid_req", report_req, 0);
    check("rst_mid_data", report_data, 8'hA0);
    exp_fc = 0;
    exp_q.delete();
    ack_hold = 0;
    tick(2);
    rst = 0;
    tick(150);
    check("after_rst_no_fault", fault_code, exp_fc);
    check("after_rst_no_req", report_req, 0);
    nand_rb_n = 1;
    tick(20);
    check("reports_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/crash_watchdog.md
CRASH_WATCHDOG -- requirements
Module: crash_watchdog

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 24'd5_000_000, max clk cycles NAND R/B# may stay low per operation.
REQ-002 Parameter BYTE_TIMEOUT, default 16'd50_000, max clk cycles between bytes inside one 4-byte UART command frame.
REQ-003 Parameter TWB_MAX, default 5'd16, cycles allowed for R/B# to fall after an operation starts.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 nand_op_start  input  1  one-cycle pulse: NAND program/erase/read command issued.
REQ-007 nand_rb_n  input  1  raw NAND ready/busy pin (0 = busy), asynchronous to clk.
REQ-008 uart_rx_valid  input  1  one-cycle pulse per received UART byte.
REQ-009 flash_len_err  input  1  one-cycle pulse: flash command length not a multiple of 4 bytes.
REQ-010 fault_clear  input  1  one-cycle pulse: host acknowledges and clears fault.
REQ-011 report_ack  input  1  UART TX accepted report byte.
REQ-012 fault_code  output  3  0 none, 1 NAND busy no response, 2 UART command incomplete, 3 flash command length error.
REQ-013 report_req  output  1  request to transmit report byte.
REQ-014 report_data  output  8  report byte {5'b10100, fault_code}.

Function
REQ-015 nand_rb_n SHALL pass through a 2-flop synchronizer; all NAND logic uses the synchronized value.
REQ-016 NAND FSM states: IDLE, WAIT_BUSY, BUSY, TIMEOUT.
REQ-017 IDLE -> WAIT_BUSY on nand_op_start; tWB counter cleared.
REQ-018 WAIT_BUSY -> BUSY when synced R/B# = 0; -> IDLE with no fault if TWB_MAX cycles elapse first.
REQ-019 BUSY: busy counter increments each cycle; -> IDLE when synced R/B# = 1; -> TIMEOUT when counter reaches BUSY_TIMEOUT.
REQ-020 TIMEOUT: one-cycle fault-1 event, then -> IDLE; counter saturates, never wraps.
REQ-021 nand_op_start outside IDLE SHALL be ignored.
REQ-022 UART frame tracker: 2-bit byte index and gap counter; index increments on uart_rx_valid, wraps 3 -> 0 (frame complete).
REQ-023 With index != 0, gap counter counts cycles since last byte; reaching BYTE_TIMEOUT raises fault-2 event and resets index to 0.
REQ-024 flash_len_err SHALL raise a fault-3 event in the same cycle.
REQ-025 fault_code priority 1 > 2 > 3; register updates next cycle only when event code is nonzero and (fault_code == 0 or event code < fault_code).
REQ-026 fault_code is sticky; fault_clear sets it to 0 unless a fault event occurs in the same cycle, in which case the event code is loaded.
REQ-027 Report FSM states: R_IDLE, R_REQ; every fault_code change to a nonzero value -> R_REQ.
REQ-028 R_REQ: report_req = 1 and report_data stable until report_ack = 1, then -> R_IDLE next cycle.
REQ-029 A fault_code change during R_REQ SHALL update report_data and keep report_req asserted; one byte sent for the latest code.

Reset
REQ-030 On rst: fault_code = 0, report_req = 0, report_data = 8'hA0, both FSMs idle, all counters and synchronizer = 0/1 (sync flops preset to 1).
REQ-031 rst mid-operation SHALL abort any timeout count and pending report with no fault recorded.

Structure
REQ-032 Shared package holds fault code constants (FAULT_NONE/NAND_BUSY/UART_INC/FLASH_LEN), report header 5'b10100 and FSM state encodings.
REQ-033 One sub-module: timeout_counter (enable, clear, limit compare, saturating), instantiated for busy and gap counters.

Verification (BUSY_TIMEOUT=100, BYTE_TIMEOUT=20, TWB_MAX=16)
REQ-034 op_start, R/B# low 50 cycles then high -> fault_code stays 0, report_req never asserts.
REQ-035 op_start, R/B# held low 200 cycles -> fault_code = 1 about 103 cycles after op_start; report_data = 8'hA1 until ack.
REQ-036 Two uart_rx_valid pulses, then idle 25 cycles -> fault_code = 2 at gap 20; 8 pulses back-to-back -> no fault.
REQ-037 flash_len_err then NAND timeout -> code 3 then 1; code 1 then flash_len_err -> stays 1.
REQ-038 fault_clear and flash_len_err in same cycle -> fault_code = 3; fault_clear alone -> 0, no report.
REQ-039 rst asserted mid-BUSY count (cycle 60) -> outputs reset immediately; after release, no fault without new op_start.
